vga_fetch_arbiter: RTL
======================

// Module: vga_fetch_arbiter
// PURPOSE
//  Feeds the 640x480 VGA scan-out with pixels from one shared single-port framebuffer memory.
//  It also shares that memory with a host write port.
//  It prefetches pixels in raster order into a first-word-fall-through (FWFT) FIFO
//  that the display timing logic pops.
//  Host writes fill idle memory slots. Display fetch wins while the FIFO is below the low-water mark.
// PARAMETERS
//  ADDR_W      32       memory/host address width (byte address)
//  DATA_W      16       pixel/memory data width (only [11:0] used as RGB444 by the display)
//  FB_BASE     0        byte address of pixel (0,0)
//  ADDR_STEP   2        byte increment per pixel
//  H_ACTIVE    640      active pixels per line
//  V_ACTIVE    480      active lines per frame
//  FIFO_DEPTH  16       prefetch FIFO entries (power of 2, >=4)
//  LOW_WATER   8        below this count, fetch has absolute priority over host
// PORTS
//  clk         in   1       system clock
//  rst         in   1       asynchronous, active-high reset
//  frame_start in   1       1-cycle pulse: new frame begins, restart fetch at pixel 0
//  pix_pop     in   1       display consumes head pixel this cycle
//  pix_data    out  DATA_W  FIFO head (FWFT), 0 when empty
//  pix_valid   out  1       FIFO non-empty
//  underflow   out  1       sticky: pop while empty; cleared by frame_start
//  host_valid  in   1       host write request (addr/wdata held stable until accepted)
//  host_ready  out  1       write accepted this cycle
//  host_addr   in   ADDR_W  host write byte address
//  host_wdata  in   DATA_W  host write data
//  mem_req     out  1       memory request, held with stable addr/we/wdata until mem_ack
//  mem_we      out  1       1=write, 0=read
//  mem_addr    out  ADDR_W  memory byte address
//  mem_wdata   out  DATA_W  memory write data
//  mem_ack     in   1       request complete; mem_rdata valid this cycle for reads
//  mem_rdata   in   DATA_W  memory read data
// BEHAVIOUR
//  Reset (async, immediate): every output, the FSM, the FIFO and the fetch state are cleared.
//   - All outputs are 0. FSM is in IDLE. FIFO is empty.
//   - pix_idx=0. Fetching is disabled (done=1) until the first frame_start.
//  FSM: IDLE, RD, WR. At most one outstanding memory request.
//  IDLE: let space = (count < FIFO_DEPTH).
//   - Go to RD if !done && space && (count<LOW_WATER || !host_valid).
//   - Otherwise go to WR if host_valid.
//   - On the transition, next cycle mem_req=1 with mem_addr/mem_we/mem_wdata registered.
//   - RD: mem_addr = FB_BASE + pix_idx*ADDR_STEP, mem_we=0.
//   - WR: mem_addr = host_addr, mem_wdata = host_wdata, mem_we=1.
//  RD: on mem_ack, push mem_rdata (unless discard set) and increment pix_idx.
//   - pix_idx == H_ACTIVE*V_ACTIVE-1 sets done.
//   - Then return to IDLE with mem_req=0 the next cycle.
//  WR: host_ready = mem_ack (combinational, WR state only). Then return to IDLE.
//  Minimum request spacing is 1 IDLE cycle, so mem_req is low for at least one cycle between requests.
//  frame_start: clears the FIFO, pix_idx=0, done=0 and underflow. The memory transaction in flight completes.
//   - An RD in flight sets discard, so its data is dropped and pix_idx is not advanced.
//   - discard clears on that ack.
//   - A WR in flight completes normally.
//  FIFO: count range 0..FIFO_DEPTH. Push and pop in the same cycle leaves count unchanged.
//   - A push is never issued when full: RD is only entered with space, and frame_start only empties the FIFO.
//  pix_pop while empty: sets underflow and nothing is popped. A same-cycle ack push still lands (no bypass).
//  frame_start and pix_pop in the same cycle: the clear wins. underflow is not set.
//  pix_idx width: ceil(log2(H_ACTIVE*V_ACTIVE)) bits. It does not wrap past the last pixel.
//   - It stops when done is set.
// TESTING
//  1. Reset, frame_start, mem_ack 1 cycle after each req, no pops.
//     -> 16 reads at addresses 0,2,..,30, then FIFO full, then mem_req stays 0.
//  2. Pop 1 pixel per 4 cycles with host_valid held high.
//     -> reads are issued whenever count<8; WR is issued only with count>=8; host_ready pulses once per write.
//  3. Full frame: pop all 307200 pixels.
//     -> last read address is 0x95FFE, done=1, no further req, underflow=0.
//  4. Pop with the FIFO empty (hold mem_ack low) -> underflow=1 and stays set until frame_start.
//  5. frame_start while in RD, before ack. -> that ack's data is not pushed; the next read is at FB_BASE; FIFO is empty.
//  6. Assert rst mid-WR -> all outputs are 0 immediately; after release there are no requests until frame_start.

Source files
------------

// File: rtl/vga_fetch_arbiter_if.sv
// Memory bus between the fetch arbiter and the shared single-port framebuffer.
// The arbiter is the master; the memory controller answers with ack/rdata.
interface vga_fetch_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/vga_fetch_arbiter.sv
// Shares one framebuffer memory between raster-order display prefetch (into an
// FWFT FIFO) and host writes; fetch wins while the FIFO is below the low-water mark.
module vga_fetch_arbiter #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 16,
  parameter logic [ADDR_W-1:0] FB_BASE    = '0,
  parameter int                ADDR_STEP  = 2,
  parameter int                H_ACTIVE   = 640,
  parameter int                V_ACTIVE   = 480,
  parameter int                FIFO_DEPTH = 16,
  parameter int                LOW_WATER  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start_i,
  input  logic              pix_pop_i,
  output logic [DATA_W-1:0] pix_data_o,
  output logic              pix_valid_o,
  output logic              underflow_o,
  input  logic              host_valid_i,
  output logic              host_ready_o,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  vga_fetch_arbiter_if.master mem
);

  localparam int TOTAL_PIX = H_ACTIVE * V_ACTIVE;
  localparam int PIX_W     = $clog2(TOTAL_PIX);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(TOTAL_PIX - 1);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t            state_q, state_d;
  logic              memReq_q, memReq_d;
  logic              memWe_q, memWe_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [DATA_W-1:0] memWdata_q, memWdata_d;
  logic [PIX_W-1:0]  pixIdx_q, pixIdx_d;
  logic              done_q, done_d;
  logic              discard_q, discard_d;
  logic              underflow_q, underflow_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [DATA_W-1:0] fifoMem [FIFO_DEPTH];

  logic              ackRd, ackWr, push, pop, wantRd, space, effDone;
  logic [CNT_W-1:0]  effCount;
  logic [PIX_W-1:0]  effIdx;
  logic [ADDR_W-1:0] fetchAddr;

  // A frame_start seen in IDLE already counts for this cycle's arbitration,
  // so the first request of the new frame is issued at pixel 0.
  always_comb begin
    effCount  = frame_start_i ? '0 : count_q;
    effDone   = frame_start_i ? 1'b0 : done_q;
    effIdx    = frame_start_i ? '0 : pixIdx_q;
    space     = effCount < CNT_W'(FIFO_DEPTH);
    wantRd    = !effDone && space && ((effCount < CNT_W'(LOW_WATER)) || !host_valid_i);
    fetchAddr = FB_BASE + ADDR_W'(effIdx) * ADDR_W'(ADDR_STEP);
    ackRd     = (state_q == RD) && mem.ack;
    ackWr     = (state_q == WR) && mem.ack;
    push      = ackRd && !discard_q && !frame_start_i;
    pop       = pix_pop_i && (count_q != '0) && !frame_start_i;
  end

  always_comb begin
    state_d    = state_q;
    memReq_d   = memReq_q;
    memWe_d    = memWe_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    case (state_q)
      IDLE: begin
        if (wantRd) begin
          state_d   = RD;
          memReq_d  = 1'b1;
          memWe_d   = 1'b0;
          memAddr_d = fetchAddr;
        end else if (host_valid_i) begin
          state_d    = WR;
          memReq_d   = 1'b1;
          memWe_d    = 1'b1;
          memAddr_d  = host_addr_i;
          memWdata_d = host_wdata_i;
        end
      end
      RD: begin
        if (mem.ack) begin
          state_d  = IDLE;
          memReq_d = 1'b0;
        end
      end
      WR: begin
        if (mem.ack) begin
          state_d  = IDLE;
          memReq_d = 1'b0;
          memWe_d  = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        memReq_d = 1'b0;
        memWe_d  = 1'b0;
      end
    endcase
  end

  // An RD still waiting for its ack when the frame restarts has stale data; drop it.
  always_comb begin
    pixIdx_d    = pixIdx_q;
    done_d      = done_q;
    discard_d   = discard_q;
    underflow_d = underflow_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    wrPtr_d     = push ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d     = pop ? rdPtr_q + 1'b1 : rdPtr_q;
    if (ackRd) begin
      discard_d = 1'b0;
    end
    if (push) begin
      if (pixIdx_q == LAST_PIX) begin
        done_d = 1'b1;
      end else begin
        pixIdx_d = pixIdx_q + 1'b1;
      end
    end
    if (pix_pop_i && (count_q == '0)) begin
      underflow_d = 1'b1;
    end
    if (frame_start_i) begin
      pixIdx_d    = '0;
      done_d      = 1'b0;
      underflow_d = 1'b0;
      count_d     = '0;
      wrPtr_d     = '0;
      rdPtr_d     = '0;
      if ((state_q == RD) && !mem.ack) begin
        discard_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      memReq_q    <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      pixIdx_q    <= '0;
      done_q      <= 1'b1;
      discard_q   <= 1'b0;
      underflow_q <= 1'b0;
      count_q     <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
    end else begin
      state_q     <= state_d;
      memReq_q    <= memReq_d;
      memWe_q     <= memWe_d;
      memAddr_q   <= memAddr_d;
      memWdata_q  <= memWdata_d;
      pixIdx_q    <= pixIdx_d;
      done_q      <= done_d;
      discard_q   <= discard_d;
      underflow_q <= underflow_d;
      count_q     <= count_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
    end
  end

  // Storage needs no reset: the head is only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtr_q] <= mem.rdata;
    end
  end

  assign pix_valid_o  = (count_q != '0);
  assign pix_data_o   = pix_valid_o ? fifoMem[rdPtr_q] : '0;
  assign underflow_o  = underflow_q;
  assign host_ready_o = ackWr;
  assign mem.req      = memReq_q;
  assign mem.we       = memWe_q;
  assign mem.addr     = memAddr_q;
  assign mem.wdata    = memWdata_q;

endmodule
